// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - fetch-side PC sequencer with flag register, branch-target LUT and run/halt FSM
// Optional taken-branch counter output TakenCount enabled by macro PC_BRANCH_STATS_EN.
module pc_branch_unit #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Halt,
  input  logic              Zero_in,
  input  logic              Negative_in,
  input  logic              FlagWrite,
  input  logic              Branch,
  input  logic [1:0]        BrCond,
  input  logic [LUT_AW-1:0] BrIdx,
  input  logic              LutWe,
  input  logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   LutData,
`ifdef PC_BRANCH_STATS_EN
  output logic [15:0]       TakenCount,
`endif
  output logic [PC_W-1:0]   PC,
  output logic              ZeroQ,
  output logic              NegQ,
  output logic              Running,
  output logic              Ack
);

  localparam int LUT_N = 1 << LUT_AW;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            zero_q, zero_d;
  logic            neg_q, neg_d;
  logic [PC_W-1:0] lut_q [LUT_N];
  logic [PC_W-1:0] lut_d [LUT_N];
  logic            cond_true;
  logic            br_taken;

`ifdef PC_BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
`endif

  // Conditions look only at the registered flags, so a same-cycle FlagWrite is not seen.
  always_comb begin
    cond_true = 1'b0;
    case (BrCond)
      2'b00:   cond_true = 1'b1;
      2'b01:   cond_true = zero_q;
      2'b10:   cond_true = ~zero_q;
      default: cond_true = neg_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    lut_d    = lut_q;
    br_taken = 1'b0;
`ifdef PC_BRANCH_STATS_EN
    taken_cnt_d = taken_cnt_q;
`endif

    if (LutWe) lut_d[LutAddr] = LutData;

    case (state_q)
      ST_IDLE: begin
        pc_d = '0;
        if (Start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (FlagWrite) begin
          zero_d = Zero_in;
          neg_d  = Negative_in;
        end
        if (Halt) begin
          state_d = ST_HALTED;
        end else if (Branch && cond_true) begin
          pc_d     = lut_q[BrIdx];
          br_taken = 1'b1;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      ST_HALTED: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          zero_d  = 1'b0;
          neg_d   = 1'b0;
`ifdef PC_BRANCH_STATS_EN
          taken_cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase

`ifdef PC_BRANCH_STATS_EN
    if (br_taken && (taken_cnt_q != 16'hFFFF)) taken_cnt_d = taken_cnt_q + 16'd1;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      for (int i = 0; i < LUT_N; i++) lut_q[i] <= '0;
`ifdef PC_BRANCH_STATS_EN
      taken_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      for (int i = 0; i < LUT_N; i++) lut_q[i] <= lut_d[i];
`ifdef PC_BRANCH_STATS_EN
      taken_cnt_q <= taken_cnt_d;
`endif
    end
  end

  assign PC      = pc_q;
  assign ZeroQ   = zero_q;
  assign NegQ    = neg_q;
  assign Running = (state_q == ST_RUN);
  assign Ack     = (state_q == ST_HALTED);
`ifdef PC_BRANCH_STATS_EN
  assign TakenCount = taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - directed self-checking bench for pc_branch_unit
// Covers TakenCount when built with PC_BRANCH_STATS_EN.
module tb_pc_branch_unit;

  logic       Clk = 1'b0;
  logic       Reset, Start, Halt, Zero_in, Negative_in, FlagWrite, Branch;
  logic [1:0] BrCond;
  logic [3:0] BrIdx, LutAddr;
  logic       LutWe;
  logic [9:0] LutData;
  logic [9:0] PC;
  logic       ZeroQ, NegQ, Running, Ack;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] TakenCount;
`endif

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_pc;

  always #5 Clk = ~Clk;

  pc_branch_unit #(.PC_W(10), .LUT_AW(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
    .Zero_in(Zero_in), .Negative_in(Negative_in), .FlagWrite(FlagWrite),
    .Branch(Branch), .BrCond(BrCond), .BrIdx(BrIdx),
    .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
`ifdef PC_BRANCH_STATS_EN
    .TakenCount(TakenCount),
`endif
    .PC(PC), .ZeroQ(ZeroQ), .NegQ(NegQ), .Running(Running), .Ack(Ack)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Start = 0; Halt = 0; Zero_in = 0; Negative_in = 0; FlagWrite = 0;
    Branch = 0; BrCond = 2'b00; BrIdx = 4'd0; LutWe = 0; LutAddr = 4'd0; LutData = 10'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1;
    tick(); tick();
    Reset = 0;
    checks++; if (PC !== 10'd0) begin errors++; $display("FAIL reset_pc got=%h exp=000", PC); end
    checks++; if ({ZeroQ, NegQ, Running, Ack} !== 4'b0000) begin errors++; $display("FAIL reset_outs got=%b exp=0000", {ZeroQ, NegQ, Running, Ack}); end
    tick();
    checks++; if ({Running, PC} !== 11'd0) begin errors++; $display("FAIL idle_hold got=%h exp=000", {Running, PC}); end
  endtask

  task automatic test_sequential();
    Start = 1; tick(); Start = 0;
    checks++; if ({Running, Ack, PC} !== {2'b10, 10'd0}) begin errors++; $display("FAIL start got=%b exp=10_0", {Running, Ack, PC}); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (PC !== 10'(i) || Running !== 1'b1 || Ack !== 1'b0) begin errors++; $display("FAIL seq_pc%0d got=%h run=%b ack=%b", i, PC, Running, Ack); end
    end
    exp_pc = 10'd5;
  endtask

  task automatic test_branch();
    LutWe = 1; LutAddr = 4'd3; LutData = 10'h040; FlagWrite = 1; Zero_in = 1;
    tick(); exp_pc = 10'd6;
    LutWe = 0; FlagWrite = 0; Zero_in = 0;
    checks++; if (ZeroQ !== 1'b1 || PC !== exp_pc) begin errors++; $display("FAIL flag_set got=%b/%h exp=1/%h", ZeroQ, PC, exp_pc); end
    Branch = 1; BrCond = 2'b01; BrIdx = 4'd3; tick();
    checks++; if (PC !== 10'h040) begin errors++; $display("FAIL br_eq got=%h exp=040", PC); end
    BrCond = 2'b10; tick();
    checks++; if (PC !== 10'h041) begin errors++; $display("FAIL br_ne got=%h exp=041", PC); end
    BrCond = 2'b11; tick();
    checks++; if (PC !== 10'h042) begin errors++; $display("FAIL br_lt got=%h exp=042", PC); end
    // same-cycle LUT rewrite and branch to that index sees the old target
    BrCond = 2'b00; LutWe = 1; LutAddr = 4'd3; LutData = 10'h100; tick();
    LutWe = 0;
    checks++; if (PC !== 10'h040) begin errors++; $display("FAIL lut_old got=%h exp=040", PC); end
    tick();
    checks++; if (PC !== 10'h100) begin errors++; $display("FAIL lut_new got=%h exp=100", PC); end
    Branch = 0; exp_pc = 10'h100;
  endtask

  task automatic test_flag_same_cycle();
    FlagWrite = 1; Zero_in = 0; Negative_in = 0; tick();
    checks++; if (ZeroQ !== 1'b0 || PC !== 10'h101) begin errors++; $display("FAIL flag_clr got=%b/%h exp=0/101", ZeroQ, PC); end
    Zero_in = 1; Branch = 1; BrCond = 2'b01; BrIdx = 4'd3; tick();
    checks++; if (PC !== 10'h102) begin errors++; $display("FAIL same_cyc_pc got=%h exp=102", PC); end
    checks++; if (ZeroQ !== 1'b1) begin errors++; $display("FAIL same_cyc_flag got=%b exp=1", ZeroQ); end
    FlagWrite = 0; Zero_in = 0; tick();
    checks++; if (PC !== 10'h100) begin errors++; $display("FAIL next_cyc_br got=%h exp=100", PC); end
    FlagWrite = 1; Negative_in = 1; Branch = 0; tick();
    FlagWrite = 0; Negative_in = 0; Branch = 1; BrCond = 2'b11; tick();
    checks++; if (PC !== 10'h100 || NegQ !== 1'b1) begin errors++; $display("FAIL br_lt_taken got=%h/%b exp=100/1", PC, NegQ); end
    Branch = 0;
  endtask

  task automatic test_wrap_halt();
    LutWe = 1; LutAddr = 4'd5; LutData = 10'h3FF; tick(); LutWe = 0;
    Branch = 1; BrCond = 2'b00; BrIdx = 4'd5; tick();
    checks++; if (PC !== 10'h3FF) begin errors++; $display("FAIL force_3ff got=%h exp=3ff", PC); end
    Branch = 0; tick();
    checks++; if (PC !== 10'h000) begin errors++; $display("FAIL wrap got=%h exp=000", PC); end
    Halt = 1; Branch = 1; FlagWrite = 1; Zero_in = 1; Negative_in = 0; tick();
    Halt = 0; Branch = 0; FlagWrite = 0;
    checks++; if (PC !== 10'h000 || Ack !== 1'b1 || Running !== 1'b0) begin errors++; $display("FAIL halt got=%h ack=%b run=%b exp=000/1/0", PC, Ack, Running); end
    checks++; if (ZeroQ !== 1'b1 || NegQ !== 1'b0) begin errors++; $display("FAIL halt_flag got=%b%b exp=10", ZeroQ, NegQ); end
    FlagWrite = 1; Zero_in = 0; Branch = 1; tick(); tick();
    FlagWrite = 0; Branch = 0;
    checks++; if (ZeroQ !== 1'b1 || PC !== 10'h000 || Ack !== 1'b1) begin errors++; $display("FAIL halted_hold got=%b/%h/%b exp=1/000/1", ZeroQ, PC, Ack); end
  endtask

  task automatic test_restart_reset();
    Start = 1; tick(); Start = 0;
    checks++; if ({Running, Ack, ZeroQ, NegQ, PC} !== {4'b1000, 10'd0}) begin errors++; $display("FAIL restart got=%b exp=1000_0", {Running, Ack, ZeroQ, NegQ, PC}); end
    for (int i = 1; i <= 7; i++) begin
      Start = (i == 3);
      tick();
    end
    Start = 0;
    checks++; if (PC !== 10'd7) begin errors++; $display("FAIL run_to7 got=%h exp=007", PC); end
    Reset = 1; tick(); Reset = 0;
    checks++; if ({Running, Ack, PC} !== 12'd0) begin errors++; $display("FAIL mid_reset got=%h exp=000", {Running, Ack, PC}); end
    Start = 1; tick(); Start = 0; tick();
    Branch = 1; BrCond = 2'b00; BrIdx = 4'd5; tick(); Branch = 0;
    checks++; if (PC !== 10'd0) begin errors++; $display("FAIL lut_cleared got=%h exp=000", PC); end
  endtask

`ifdef PC_BRANCH_STATS_EN
  task automatic test_stats();
    Reset = 1; tick(); Reset = 0;
    checks++; if (TakenCount !== 16'd0) begin errors++; $display("FAIL cnt_reset got=%0d exp=0", TakenCount); end
    Start = 1; tick(); Start = 0;
    FlagWrite = 1; Zero_in = 1; tick(); FlagWrite = 0; Zero_in = 0;
    Branch = 1; BrIdx = 4'd0;
    BrCond = 2'b01; tick();
    BrCond = 2'b10; tick();
    BrCond = 2'b00; tick();
    BrCond = 2'b11; tick();
    BrCond = 2'b01; tick();
    Halt = 1; BrCond = 2'b00; tick();
    Halt = 0; Branch = 0;
    checks++; if (TakenCount !== 16'd3 || Ack !== 1'b1) begin errors++; $display("FAIL cnt3 got=%0d ack=%b exp=3/1", TakenCount, Ack); end
    Start = 1; tick(); Start = 0;
    checks++; if (TakenCount !== 16'd0) begin errors++; $display("FAIL cnt_restart got=%0d exp=0", TakenCount); end
  endtask
`endif

  initial begin
    Reset = 1;
    idle_inputs();
    exp_pc = 10'd0;
    test_reset();
    test_sequential();
    test_branch();
    test_flag_same_cycle();
    test_wrap_halt();
    test_restart_reset();
`ifdef PC_BRANCH_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Fetch-side sequencer. Consumes the ALU's Zero/Negative outputs, holds them in a flag register, and produces the program counter.
- Resolves conditional branches against the flag register, using a loadable absolute-target lookup table indexed by the instruction's branch field.
- Controls the program run/halt lifecycle with a Start/Ack handshake toward the testbench/top level.

Parameters:
- PC_W, 10, program counter width in bits.
- LUT_AW, 4, branch-target LUT address width (2^LUT_AW entries of PC_W bits).

Ports:
- Clk  input  1  system clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  begin or restart program execution.
- Halt  input  1  decoded halt instruction, sampled only in RUN.
- Zero_in  input  1  ALU Zero flag.
- Negative_in  input  1  ALU Negative flag.
- FlagWrite  input  1  latch Zero_in/Negative_in into the flag register (CMP/arith instructions).
- Branch  input  1  current instruction is a branch.
- BrCond  input  2  branch condition: 00 always, 01 eq (Z=1), 10 ne (Z=0), 11 lt (N=1).
- BrIdx  input  LUT_AW  LUT index of the branch target.
- LutWe  input  1  LUT write enable.
- LutAddr  input  LUT_AW  LUT write address.
- LutData  input  PC_W  LUT write data (absolute target).
- PC  output  PC_W  current instruction address.
- ZeroQ  output  1  registered Zero flag.
- NegQ  output  1  registered Negative flag.
- Running  output  1  high while in RUN.
- Ack  output  1  high while in HALTED (program done).

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high, named Reset.
- Reset: state=IDLE, PC=0, ZeroQ=0, NegQ=0, Running=0, Ack=0, all LUT entries=0. Reset overrides every other input, including mid-RUN.
- States:
  - IDLE: PC held at 0. If Start=1, go to RUN next edge with PC=0.
  - RUN: Running=1. Each edge, exactly one of the following, in priority order:
    1. Halt=1: go to HALTED, PC holds.
    2. Branch=1 and condition true: PC <= LUT[BrIdx].
    3. Otherwise: PC <= PC+1, modulo 2^PC_W (all-ones wraps to 0, no flag).
  - HALTED: Ack=1, PC holds. Start=1 restarts: next edge state=RUN, PC=0, ZeroQ=NegQ=0.
  - Start is ignored in RUN.
- Branch condition: evaluated on the registered ZeroQ/NegQ, never on Zero_in/Negative_in.
- Flags: FlagWrite is honoured in RUN only and ignored in IDLE/HALTED. ZeroQ<=Zero_in, NegQ<=Negative_in at the edge. With FlagWrite and Branch in the same cycle, the branch uses the old flags and the new flags are visible the following cycle.
- Halt and Branch in the same cycle: Halt wins, PC holds, the flag write still occurs if FlagWrite=1.
- LUT:
  - Writable in any state.
  - Write takes effect at the edge.
  - Same-cycle write and branch to the same index uses the old entry.
- Latency:
  - PC changes one edge after the controlling inputs.
  - Outputs are registered; no combinational path from inputs to PC, ZeroQ or NegQ.
  - Running and Ack decode state only.

Optional Feature:
- Macro: PC_BRANCH_STATS_EN.
- When defined: add output TakenCount (16 bits), reset to 0.
  - Increments on every edge where a branch is taken in RUN; Halt-suppressed branches do not count.
  - Saturates at 16'hFFFF.
  - Cleared on restart from HALTED.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then Start pulse, no branches for 5 cycles -> PC sequence 0,1,2,3,4,5; Running=1; Ack=0.
- LutWe addr 3 data 10'h040; FlagWrite with Zero_in=1; next cycle Branch BrCond=01 BrIdx=3 -> PC=0x040; same setup with BrCond=10 -> PC=prior+1.
- FlagWrite with Zero_in=1 and Branch BrCond=01 in the same cycle, ZeroQ previously 0 -> not taken (PC+1); ZeroQ=1 the next cycle.
- Force PC to 0x3FF via a LUT branch, then no branch -> PC=0x000; Halt and Branch(taken) in the same cycle -> PC holds, Ack=1 next cycle.
- In HALTED with ZeroQ=1, Start pulse -> state RUN, PC=0, ZeroQ=0, Ack=0; Reset asserted mid-RUN at PC=7 -> next edge PC=0, IDLE, LUT cleared.
- With PC_BRANCH_STATS_EN: 3 taken and 2 not-taken branches -> TakenCount=3; restart from HALTED -> TakenCount=0.
